osc_clk_supervisor: RTL and testbench

Clock-source supervisor for the on-chip oscillator block. It runs on the RC 50 MHz fabric clock and measures the external-crystal fabric clock against it over fixed windows. After a programmable number of consecutive out-of-range windows it sequences a switchover request to the downstream glitchless clock mux, waits for the mux acknowledge, and supports a software-initiated restore to the primary source.

---
 rtl/osc_clk_supervisor.sv | 183 ++++++++++++++++++
 tb/tb_osc_clk_supervisor.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_clk_supervisor.sv
// Purpose: measures MON_CLK against CLK over fixed windows; after FAIL_LIMIT bad windows in a row it requests the backup clock and tracks the mux handshake.
// Latency: a MON_CLK edge is counted 3 cycles later; COUNT_VALID every WINDOW+1 cycles; SEL_ACK acted on 3 edges after it changes.
// Backpressure: none; the mux handshake is the SEL_REQ/SEL_ACK level pair, guarded by a sticky timeout flag.
module osc_clk_supervisor #(
  parameter int WINDOW      = 1000,
  parameter int EXPECT      = 400,
  parameter int TOL         = 8,
  parameter int FAIL_LIMIT  = 3,
  parameter int ACK_TIMEOUT = 256,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             MON_CLK,
  input  logic             ENABLE,
  input  logic             CLEAR,
  input  logic             SEL_ACK,
  output logic             SEL_REQ,
  output logic             FAULT,
  output logic             SWITCH_TIMEOUT,
  output logic             COUNT_VALID,
  output logic [CNT_W-1:0] LAST_COUNT,
  output logic             IN_RANGE
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(ACK_TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MEASURE = 3'd1;
  localparam logic [2:0] S_EVAL    = 3'd2;
  localparam logic [2:0] S_SWITCH  = 3'd3;
  localparam logic [2:0] S_BACKUP  = 3'd4;
  localparam logic [2:0] S_RESTORE = 3'd5;

  logic [2:0]       state;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [3:0]       fail_cnt;
  logic [TO_W-1:0]  to_cnt;

  logic mon_s1, mon_s2, mon_s3;
  logic ack_s1, ack_s2;

  logic                    mon_edge;
  logic [CNT_W-1:0]        edge_inc;
  logic signed [CNT_W+1:0] diff;
  logic signed [CNT_W+1:0] diff_abs;
  logic                    in_rng;
  logic [3:0]              fail_nxt;
  logic                    fail_trip;
  logic                    to_hit;
  logic                    clr_to;

  assign mon_edge = mon_s2 & ~mon_s3;
  assign edge_inc = (edge_cnt == '1) ? edge_cnt : edge_cnt + 1'b1;

  // Window result: signed distance from the expected count, two guard bits so EXPECT never wraps.
  assign diff     = $signed({2'b00, edge_cnt}) - $signed((CNT_W+2)'(EXPECT));
  assign diff_abs = diff[CNT_W+1] ? -diff : diff;
  assign in_rng   = (diff_abs <= $signed((CNT_W+2)'(TOL)));

  assign fail_nxt  = in_rng ? 4'd0 : ((fail_cnt == 4'hF) ? fail_cnt : fail_cnt + 4'd1);
  assign fail_trip = (fail_nxt >= 4'(FAIL_LIMIT));
  assign to_hit    = (to_cnt == TO_LAST);

  // CLEAR outside BACKUP only drops the timeout flag, and loses to a switchover taken in the same cycle.
  assign clr_to = CLEAR && (state != S_BACKUP) && !((state == S_EVAL) && ENABLE && fail_trip);

  // Synchronizers: MON_CLK gets an extra stage for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mon_s1 <= 1'b0;
      mon_s2 <= 1'b0;
      mon_s3 <= 1'b0;
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      mon_s1 <= MON_CLK;
      mon_s2 <= mon_s1;
      mon_s3 <= mon_s2;
      ack_s1 <= SEL_ACK;
      ack_s2 <= ack_s1;
    end
  end

  // Supervisor FSM: measurement windows, switchover sequencing and restore.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= S_IDLE;
      win_cnt        <= '0;
      edge_cnt       <= '0;
      fail_cnt       <= '0;
      to_cnt         <= '0;
      SEL_REQ        <= 1'b0;
      FAULT          <= 1'b0;
      SWITCH_TIMEOUT <= 1'b0;
      COUNT_VALID    <= 1'b0;
      LAST_COUNT     <= '0;
      IN_RANGE       <= 1'b0;
    end else begin
      COUNT_VALID <= 1'b0;
      if (clr_to) SWITCH_TIMEOUT <= 1'b0;

      case (state)
        S_IDLE: begin
          win_cnt  <= '0;
          edge_cnt <= '0;
          fail_cnt <= '0;
          if (ENABLE) state <= S_MEASURE;
        end

        S_MEASURE: begin
          if (!ENABLE) begin
            state    <= S_IDLE;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            if (mon_edge) edge_cnt <= edge_inc;
            if (win_cnt == WIN_LAST) state <= S_EVAL;
            else                     win_cnt <= win_cnt + 1'b1;
          end
        end

        S_EVAL: begin
          // Edges seen in this cycle are dropped: the next window starts from zero.
          win_cnt  <= '0;
          edge_cnt <= '0;
          if (!ENABLE) begin
            state <= S_IDLE;
          end else begin
            LAST_COUNT  <= edge_cnt;
            IN_RANGE    <= in_rng;
            COUNT_VALID <= 1'b1;
            fail_cnt    <= fail_nxt;
            if (fail_trip) begin
              SEL_REQ <= 1'b1;
              FAULT   <= 1'b1;
              to_cnt  <= '0;
              state   <= S_SWITCH;
            end else begin
              state <= S_MEASURE;
            end
          end
        end

        S_SWITCH: begin
          if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
          if (to_hit)           SWITCH_TIMEOUT <= 1'b1;
          if (ack_s2)           state <= S_BACKUP;
        end

        S_BACKUP: begin
          if (CLEAR) begin
            SEL_REQ        <= 1'b0;
            FAULT          <= 1'b0;
            SWITCH_TIMEOUT <= 1'b0;
            fail_cnt       <= '0;
            to_cnt         <= '0;
            state          <= S_RESTORE;
          end
        end

        S_RESTORE: begin
          if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
          if (to_hit)           SWITCH_TIMEOUT <= 1'b1;
          if (!ack_s2) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
            state    <= S_MEASURE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_clk_supervisor.sv
// Bench for osc_clk_supervisor: table of exact-edge windows, hand-written switchover/restore/reset sequences,
// and randomized MON_CLK traffic checked against a window-arithmetic model.
// All stimulus is driven 1 ns after a CLK rising edge; outputs are sampled at the same point.
module tb_osc_clk_supervisor;

  localparam int W = 1000;

  typedef struct {
    int n;
    bit exp_in;
    bit exp_sw;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        sel_ack = 1'b0;
  logic        mon_drv = 1'b0;
  logic        mon_free = 1'b0;
  logic        free_en = 1'b0;
  logic        mon_clk;
  logic        sel_req, fault, sw_to, cnt_vld, in_range;
  logic [15:0] last_cnt;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int vld_cnt = 0;
  int mode = 0;
  int plan_start = 0;
  int plan_n = 0;
  int lo_left = 0;
  int pct = 50;
  int rise_q[$];

  assign mon_clk = free_en ? mon_free : mon_drv;

  always #10 clk = ~clk;

  // Free-running 20 MHz monitored clock, offset so its edges never coincide with CLK edges.
  initial begin
    #3;
    forever #25 mon_free = ~mon_free;
  end

  osc_clk_supervisor dut (
    .CLK            (clk),
    .RESET          (rst),
    .MON_CLK        (mon_clk),
    .ENABLE         (enable),
    .CLEAR          (clear),
    .SEL_ACK        (sel_ack),
    .SEL_REQ        (sel_req),
    .FAULT          (fault),
    .SWITCH_TIMEOUT (sw_to),
    .COUNT_VALID    (cnt_vld),
    .LAST_COUNT     (last_cnt),
    .IN_RANGE       (in_range)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input logic [63:0] act, input int lo, input int hi);
    n_chk++;
    if ($isunknown(act) || act < 64'(lo) || act > 64'(hi)) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d..%0d", nm, cyc, act, lo, hi);
    end
  endtask

  // One clock: advance, sample, then drive MON_CLK for the next edge according to the mode.
  task automatic tick();
    int off;
    @(posedge clk);
    cyc++;
    #1;
    if (cnt_vld === 1'b1) vld_cnt++;
    case (mode)
      1: begin
        off = cyc - plan_start;
        mon_drv = (off >= 0) && (off < 2 * plan_n) && (off % 2 == 0);
      end
      2: begin
        if (cyc % 200 == 0) pct = 40 + 10 * int'($urandom_range(2, 0));
        if (mon_drv) begin
          mon_drv = 1'b0;
          lo_left = (int'($urandom_range(99, 0)) < pct) ? 1 : 0;
        end else if (lo_left > 0) begin
          lo_left--;
        end else begin
          mon_drv = 1'b1;
          rise_q.push_back(cyc);
        end
      end
      default: mon_drv = 1'b0;
    endcase
  endtask

  task automatic run_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic do_reset();
    mode = 0; free_en = 1'b0; mon_drv = 1'b0;
    enable = 1'b0; clear = 1'b0; sel_ack = 1'b0;
    rise_q.delete();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_sel_req"}, sel_req, 0);
    chk({nm, "_fault"}, fault, 0);
    chk({nm, "_timeout"}, sw_to, 0);
    chk({nm, "_count_valid"}, cnt_vld, 0);
    chk({nm, "_last_count"}, last_cnt, 0);
    chk({nm, "_in_range"}, in_range, 0);
  endtask

  // A window measured from MEASURE entry at edge e0 reports at edge e0+W+1, as the only pulse since the caller zeroed vld_cnt.
  task automatic end_window(input int e0, input string nm);
    run_until(e0 + W + 1);
    chk({nm, "_vld"}, cnt_vld, 1);
    chk({nm, "_vld_pulses"}, vld_cnt, 1);
  endtask

  initial begin
    vec_t tbl[6];
    int   e0, ts, total, streak, exp_n;
    bit   exp_in;

    tbl[0] = '{408, 1'b1, 1'b0};
    tbl[1] = '{409, 1'b0, 1'b0};
    tbl[2] = '{392, 1'b1, 1'b0};
    tbl[3] = '{391, 1'b0, 1'b0};
    tbl[4] = '{391, 1'b0, 1'b0};
    tbl[5] = '{409, 1'b0, 1'b1};

    // Reset state
    repeat (2) tick();
    chk_reset_outs("reset");
    rst = 1'b0;
    tick();

    // Nominal: 20 MHz against 50 MHz, 400 edges per 1000-cycle window
    free_en = 1'b1;
    e0 = cyc + 1;
    enable = 1'b1;
    for (int j = 0; j < 20; j++) begin
      vld_cnt = 0;
      end_window(e0, "nom");
      chk_rng("nom_count", last_cnt, 399, 401);
      chk("nom_in_range", in_range, 1);
      chk("nom_sel_req", sel_req, 0);
      e0 += W + 1;
    end
    do_reset();

    // Exact-edge table: tolerance boundaries, then bad/good/bad/bad/bad with CLEAR in the switching EVAL
    mode = 1;
    e0 = cyc + 1;
    plan_start = e0 + 1;
    plan_n = tbl[0].n;
    enable = 1'b1;
    for (int j = 0; j < 6; j++) begin
      vld_cnt = 0;
      if (tbl[j].exp_sw) begin
        run_until(e0 + W);
        clear = 1'b1;
      end
      end_window(e0, "tbl");
      clear = 1'b0;
      chk("tbl_count", last_cnt, tbl[j].n);
      chk("tbl_in_range", in_range, tbl[j].exp_in);
      chk("tbl_sel_req", sel_req, tbl[j].exp_sw);
      chk("tbl_fault", fault, tbl[j].exp_sw);
      e0 += W + 1;
      if (j < 5) begin
        plan_start = e0 + 1;
        plan_n = tbl[j + 1].n;
      end
    end
    ts = cyc;
    mode = 0;

    // Ack timeout: SEL_ACK stuck low
    run_until(ts + 255);
    chk("to_before_256", sw_to, 0);
    tick();
    chk("to_at_256", sw_to, 1);
    run_until(ts + 260);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_in_switch_to", sw_to, 0);
    chk("clr_in_switch_req", sel_req, 1);
    chk("clr_in_switch_fault", fault, 1);
    run_until(ts + 270);
    sel_ack = 1'b1;
    run_until(ts + 280);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("late_ack_backup_req", sel_req, 0);
    chk("late_ack_backup_fault", fault, 0);
    do_reset();

    // Stopped clock: three empty windows, switchover, ack, CLEAR, restore
    e0 = cyc + 1;
    enable = 1'b1;
    for (int j = 0; j < 3; j++) begin
      vld_cnt = 0;
      end_window(e0, "stop");
      chk("stop_count", last_cnt, 0);
      chk("stop_in_range", in_range, 0);
      chk("stop_sel_req", sel_req, (j == 2));
      chk("stop_fault", fault, (j == 2));
      e0 += W + 1;
    end
    ts = cyc;
    run_until(ts + 10);
    sel_ack = 1'b1;
    run_until(ts + 20);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("restore_sel_req", sel_req, 0);
    chk("restore_fault", fault, 0);
    run_until(ts + 30);
    sel_ack = 1'b0;
    e0 = ts + 33;
    vld_cnt = 0;
    end_window(e0, "resume");
    chk("resume_count", last_cnt, 0);
    chk("resume_sel_req", sel_req, 0);
    chk("resume_timeout", sw_to, 0);

    // Two more empty windows trip the switchover again; RESET while in SWITCH
    for (int j = 0; j < 2; j++) begin
      e0 += W + 1;
      vld_cnt = 0;
      end_window(e0, "stop2");
      chk("stop2_sel_req", sel_req, (j == 1));
    end
    ts = cyc;
    run_until(ts + 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outs("rst_in_switch");
    e0 = ts + 7;
    vld_cnt = 0;
    end_window(e0, "after_rst");
    chk("after_rst_sel_req", sel_req, 0);

    // Abort: ENABLE drops 500 cycles into a window
    e0 = cyc;
    vld_cnt = 0;
    run_until(e0 + 500);
    enable = 1'b0;
    run_until(e0 + W + 10);
    chk("abort_no_vld", vld_cnt, 0);
    e0 = cyc + 1;
    enable = 1'b1;
    vld_cnt = 0;
    end_window(e0, "reenable");
    chk("reenable_sel_req", sel_req, 0);

    // Randomized MON_CLK against the window-arithmetic model
    total = 0;
    while (total < 12) begin
      do_reset();
      streak = 0;
      mode = 2;
      e0 = cyc + 1;
      enable = 1'b1;
      for (int j = 0; j < 12 && total < 12; j++) begin
        vld_cnt = 0;
        end_window(e0, "rnd");
        // A rise driven after edge k is detected in cycle k+2 and counts if that cycle is inside the window.
        exp_n = 0;
        foreach (rise_q[i])
          if (rise_q[i] + 2 >= e0 && rise_q[i] + 2 <= e0 + W - 1) exp_n++;
        exp_in = ((exp_n > 400) ? exp_n - 400 : 400 - exp_n) <= 8;
        streak = exp_in ? 0 : streak + 1;
        chk("rnd_count", last_cnt, exp_n);
        chk("rnd_in_range", in_range, exp_in);
        chk("rnd_sel_req", sel_req, (streak >= 3));
        chk("rnd_fault", fault, (streak >= 3));
        total++;
        while (rise_q.size() > 0 && rise_q[0] + 2 < e0 + W) void'(rise_q.pop_front());
        e0 += W + 1;
        if (streak >= 3) break;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
